// File: rtl/cpu_exec_units.sv
// Execution front-end: ALU, load-data extender and immediate generator evaluated in parallel.
// Latency: 1 cycle from in_valid to out_valid; results hold while idle.
// No backpressure: one result per accepted cycle. Optional `CPU_EXEC_ERR_CHECK_EN flags illegal controls on err.
module cpu_exec_units (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [3:0]  alu_control,
    input  logic [31:0] ext_data,
    input  logic [2:0]  ext_control,
    input  logic [24:0] imm_data,
    input  logic [2:0]  imm_src,
    output logic        out_valid,
    output logic [31:0] alu_result,
    output logic        alu_zero,
    output logic        alu_lt,
    output logic        alu_borrow,
    output logic [31:0] data_ext,
    output logic [31:0] imm_ext,
    output logic        err
);

    logic [31:0] alu_c;
    logic [31:0] ext_c;
    logic [31:0] imm_c;
    logic [31:7] instr;
    logic [4:0]  shamt;
    logic        lt_c;
    logic        borrow_c;

    // Keep original instruction bit numbering so the immediate formats read like the ISA manual.
    assign instr    = imm_data;
    assign shamt    = alu_b[4:0];
    assign lt_c     = $signed(alu_a) < $signed(alu_b);
    assign borrow_c = alu_a < alu_b;

    always_comb begin
        alu_c = '0;
        case (alu_control)
            4'b0000: alu_c = alu_a + alu_b;
            4'b1000: alu_c = alu_a - alu_b;
            4'b0001: alu_c = alu_a << shamt;
            4'b0010: alu_c = {31'd0, lt_c};
            4'b0011: alu_c = {31'd0, borrow_c};
            4'b0100: alu_c = alu_a ^ alu_b;
            4'b0101: alu_c = alu_a >> shamt;
            4'b1101: alu_c = 32'($signed(alu_a) >>> shamt);
            4'b0110: alu_c = alu_a | alu_b;
            4'b0111: alu_c = alu_a & alu_b;
            default: alu_c = '0;
        endcase
    end

    always_comb begin
        ext_c = '0;
        case (ext_control)
            3'b000:  ext_c = {{24{ext_data[7]}}, ext_data[7:0]};
            3'b001:  ext_c = {{16{ext_data[15]}}, ext_data[15:0]};
            3'b010:  ext_c = ext_data;
            3'b100:  ext_c = {24'd0, ext_data[7:0]};
            3'b101:  ext_c = {16'd0, ext_data[15:0]};
            default: ext_c = '0;
        endcase
    end

    always_comb begin
        imm_c = '0;
        case (imm_src)
            3'd0:    imm_c = {{20{instr[31]}}, instr[31:20]};
            3'd1:    imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'd2:    imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'd3:    imm_c = {instr[31:12], 12'd0};
            3'd4:    imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            alu_result <= '0;
            alu_zero   <= 1'b0;
            alu_lt     <= 1'b0;
            alu_borrow <= 1'b0;
            data_ext   <= '0;
            imm_ext    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                alu_result <= alu_c;
                alu_zero   <= (alu_c == 32'd0);
                alu_lt     <= lt_c;
                alu_borrow <= borrow_c;
                data_ext   <= ext_c;
                imm_ext    <= imm_c;
            end
        end
    end

`ifdef CPU_EXEC_ERR_CHECK_EN
    logic err_c;

    assign err_c = !(alu_control inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                         4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111})
                || !(ext_control inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                || (imm_src > 3'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (in_valid) begin
            err <= err_c;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_exec_units.sv
// Scoreboard bench for cpu_exec_units: driver pushes reference results, monitor pops on out_valid.
module tb_cpu_exec_units;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        lt;
        logic        br;
        logic [31:0] de;
        logic [31:0] ie;
        logic        er;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] alu_a = '0;
    logic [31:0] alu_b = '0;
    logic [3:0]  alu_control = '0;
    logic [31:0] ext_data = '0;
    logic [2:0]  ext_control = '0;
    logic [24:0] imm_data = '0;
    logic [2:0]  imm_src = '0;
    logic        out_valid;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_lt;
    logic        alu_borrow;
    logic [31:0] data_ext;
    logic [31:0] imm_ext;
    logic        err;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t last = '0;

    cpu_exec_units dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .ext_data(ext_data), .ext_control(ext_control),
        .imm_data(imm_data), .imm_src(imm_src),
        .out_valid(out_valid), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_borrow(alu_borrow),
        .data_ext(data_ext), .imm_ext(imm_ext), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                                   input logic [31:0] ed, input logic [2:0] ec,
                                   input logic [31:0] instr, input logic [2:0] isrc);
        exp_t        m;
        int unsigned sh;
        logic [31:0] bias;
        logic [12:0] bimm;
        logic [20:0] jimm;
        sh   = int'(b[4:0]);
        bias = 32'h8000_0000;
        m    = '0;
        m.lt = (a ^ bias) < (b ^ bias);
        m.br = a < b;
        case (ctrl)
            4'b0000: m.res = a + b;
            4'b1000: m.res = a - b;
            4'b0001: m.res = a << sh;
            4'b0010: m.res = m.lt ? 32'd1 : 32'd0;
            4'b0011: m.res = m.br ? 32'd1 : 32'd0;
            4'b0100: m.res = a ^ b;
            4'b0101: m.res = a >> sh;
            4'b1101: m.res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'b0110: m.res = a | b;
            4'b0111: m.res = a & b;
            default: m.res = 32'd0;
        endcase
        m.z = (m.res == 32'd0);
        case (ec)
            3'b000:  m.de = 32'($signed(ed[7:0]));
            3'b001:  m.de = 32'($signed(ed[15:0]));
            3'b010:  m.de = ed;
            3'b100:  m.de = 32'(ed[7:0]);
            3'b101:  m.de = 32'(ed[15:0]);
            default: m.de = 32'd0;
        endcase
        bimm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        jimm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        case (isrc)
            3'd0:    m.ie = 32'($signed(instr) >>> 20);
            3'd1:    m.ie = (32'($signed(instr) >>> 20) & ~32'h1F) | 32'(instr[11:7]);
            3'd2:    m.ie = 32'($signed(bimm));
            3'd3:    m.ie = instr & 32'hFFFF_F000;
            3'd4:    m.ie = 32'($signed(jimm));
            default: m.ie = 32'd0;
        endcase
`ifdef CPU_EXEC_ERR_CHECK_EN
        m.er = !(ctrl inside {4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7})
            || !(ec inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (isrc > 3'd4);
`else
        m.er = 1'b0;
`endif
        return m;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                         input logic [31:0] ed, input logic [2:0] ec,
                         input logic [31:0] instr, input logic [2:0] isrc);
        @(negedge clk);
        in_valid    = 1'b1;
        alu_a       = a;
        alu_b       = b;
        alu_control = ctrl;
        ext_data    = ed;
        ext_control = ec;
        imm_data    = instr[31:7];
        imm_src     = isrc;
        q.push_back(model(a, b, ctrl, ed, ec, instr, isrc));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        alu_a    = $urandom;
        alu_b    = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_res"}, alu_result, 32'd0);
        chk({tag, "_flags"}, {29'd0, alu_zero, alu_lt, alu_borrow}, 32'd0);
        chk({tag, "_dext"}, data_ext, 32'd0);
        chk({tag, "_imm"}, imm_ext, 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Monitor: compare on out_valid, otherwise confirm the last result is held.
    initial begin
        logic v_at_edge;
        logic r_at_edge;
        exp_t e;
        forever begin
            @(posedge clk);
            v_at_edge = in_valid;
            r_at_edge = rst_n;
            #1;
            if (!r_at_edge || !rst_n) begin
                chk("valid_in_reset", 32'(out_valid), 32'd0);
            end else begin
                chk("valid", 32'(out_valid), 32'(v_at_edge));
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("underflow", 32'(q.size()), 32'd1);
                        e = last;
                    end else begin
                        e = q.pop_front();
                    end
                    last = e;
                end else begin
                    e = last;
                end
                chk("alu_result", alu_result, e.res);
                chk("alu_zero", 32'(alu_zero), 32'(e.z));
                chk("alu_lt", 32'(alu_lt), 32'(e.lt));
                chk("alu_borrow", 32'(alu_borrow), 32'(e.br));
                chk("data_ext", data_ext, e.de);
                chk("imm_ext", imm_ext, e.ie);
                chk("err", 32'(err), 32'(e.er));
            end
        end
    end

    initial begin
        #3;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors from the datasheet examples.
        issue(32'd5, 32'd7, 4'b1000, 32'h1234_80F0, 3'b000, 32'hFFF0_0093, 3'd0);
        issue(32'hFFFF_FFFF, 32'd1, 4'b0000, 32'h1234_80F0, 3'b100, 32'hFE00_0EE3, 3'd2);
        issue(32'h8000_0000, 32'd4, 4'b1101, 32'h1234_80F0, 3'b001, 32'hFFF0_0093, 3'd3);
        issue(32'h8000_0000, 32'd4, 4'b0101, 32'h1234_80F0, 3'b101, 32'hFFF0_0093, 3'd1);
        issue(32'h8000_0001, 32'h24, 4'b0001, 32'h1234_80F0, 3'b011, 32'hFFF0_0093, 3'd4);
        issue(32'd3, 32'd3, 4'b1000, 32'h1234_80F0, 3'b010, 32'h8000_0000, 3'd5);
        issue(32'd1, 32'd2, 4'b1111, 32'h0000_0080, 3'b111, 32'h7FF0_0093, 3'd7);
        idle();
        idle();
        // Two back-to-back then idle: second result must be held.
        issue(32'h7FFF_FFFF, 32'h8000_0000, 4'b0010, 32'h0000_FF7F, 3'b000, 32'h8000_0FE3, 3'd2);
        issue(32'h7FFF_FFFF, 32'h8000_0000, 4'b0011, 32'h0000_FF7F, 3'b001, 32'h8000_006F, 3'd4);
        idle();
        idle();

        // Reset mid-stream discards the pending capture.
        issue(32'd9, 32'd1, 4'b0000, 32'hFFFF_FFFF, 3'b010, 32'hFFF0_0093, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        q.delete();
        last = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) begin
                idle();
            end else begin
                issue($urandom, ($urandom_range(1) == 0) ? 32'($urandom_range(40)) : $urandom,
                      4'($urandom), $urandom, 3'($urandom), $urandom, 3'($urandom_range(7)));
            end
        end
        idle();
        idle();
        idle();
        chk("drain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_exec_units.md
CPU_EXEC_UNITS -- requirements
Module: cpu_exec_units

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands valid; capture on this clk edge.
REQ-005 alu_a  input  32  ALU source A.
REQ-006 alu_b  input  32  ALU source B.
REQ-007 alu_control  input  4  ALU op, encoded {funct7[5], funct3}.
REQ-008 ext_data  input  32  raw load word, lane pre-aligned to bit 0.
REQ-009 ext_control  input  3  load funct3.
REQ-010 imm_data  input  25  instruction bits [31:7]; imm_data[k] = instr[k+7].
REQ-011 imm_src  input  3  immediate format: 0=I, 1=S, 2=B, 3=U, 4=J.
REQ-012 out_valid  output  1  registered results valid.
REQ-013 alu_result  output  32  ALU result.
REQ-014 alu_zero / alu_lt / alu_borrow  output  1 each  result==0 / signed A<B / unsigned A<B.
REQ-015 data_ext  output  32  extended load data.
REQ-016 imm_ext  output  32  extended immediate.
REQ-017 err  output  1  illegal control flag (see Configuration).

Function
REQ-018 All outputs SHALL be registered; latency exactly 1 cycle from in_valid=1 edge to out_valid=1 with matching results.
REQ-019 in_valid=0 at an edge: out_valid<=0; result outputs hold their previous values.
REQ-020 Back-to-back in_valid SHALL give one result per cycle, no bubbles.
REQ-021 ALU ops: 0000 add; 1000 sub; 0001 sll; 0010 slt; 0011 sltu; 0100 xor; 0101 srl; 1101 sra; 0110 or; 0111 and; any other code -> result 0.
REQ-022 Add/sub wrap modulo 2^32; shift amount = alu_b[4:0]; slt/sltu yield 0 or 1 zero-extended.
REQ-023 alu_zero = (computed result == 0); alu_lt = signed(alu_a) < signed(alu_b) and alu_borrow = unsigned(alu_a) < unsigned(alu_b), both independent of alu_control.
REQ-024 Data ext: 000 sign-ext [7:0]; 001 sign-ext [15:0]; 010 pass 32 bits; 100 zero-ext [7:0]; 101 zero-ext [15:0]; other codes -> 0.
REQ-025 Imm I: sext instr[31:20]; S: sext {instr[31:25],instr[11:7]}; B: sext {instr[31],instr[7],instr[30:25],instr[11:8],0}; U: {instr[31:12],12'b0}; J: sext {instr[31],instr[19:12],instr[20],instr[30:21],0}; imm_src 5-7 -> 0.
REQ-026 The three units SHALL evaluate independently in the same cycle; an illegal code in one SHALL NOT affect the others.

Reset
REQ-027 rst_n=0 SHALL immediately clear out_valid, alu_result, all flags, data_ext, imm_ext and err to 0, regardless of clk.
REQ-028 Reset asserted mid-stream SHALL discard the in-flight result; first capture occurs on the first rising edge with rst_n=1 and in_valid=1.

Configuration
REQ-029 Macro CPU_EXEC_ERR_CHECK_EN: when defined, err is registered with the other outputs and equals 1 if alu_control is not a REQ-021 code, ext_control not a REQ-024 code, or imm_src > 4.
REQ-030 Without CPU_EXEC_ERR_CHECK_EN, the err port SHALL exist and be tied to 0; all other behaviour unchanged.

Verification
REQ-031 Reset: hold rst_n=0 mid-cycle -> all outputs 0 immediately, out_valid=0.
REQ-032 alu_a=5, alu_b=7, ctrl=1000 -> next cycle result 0xFFFFFFFE, zero=0, lt=1, borrow=1; alu_a=0xFFFFFFFF, alu_b=1 -> lt=1, borrow=0.
REQ-033 alu_a=0x80000000, alu_b=4: ctrl 1101 -> 0xF8000000; ctrl 0101 -> 0x08000000; alu_b=0x24, ctrl 0001 -> shift by 4.
REQ-034 ext_data=0x1234_80F0: ctrl 000 -> 0xFFFFFFF0; 100 -> 0x000000F0; 001 -> 0xFFFF80F0; 101 -> 0x000080F0; 011 -> 0 (err=1 with macro).
REQ-035 Instruction 0xFFF00093 (imm_data=instr[31:7]), imm_src=0 -> 0xFFFFFFFF; instruction 0xFE000EE3, imm_src=2 -> 0xFFFFFFFC; imm_src=3 on 0xFFF00093 -> 0xFFF00000.
REQ-036 Two consecutive in_valid cycles then in_valid=0 -> out_valid 1,1,0 with second result held on the idle cycle.
